mem_arbiter: RTL

Shares the CPU's single memory port between the instruction-fetch requester (I) and the load/store requester (D). Each accepted request runs as one memory transaction. Requests are granted round-robin under contention, and a watchdog terminates any transaction the memory does not acknowledge in time. The block sits between the fetch/MEM stages and the external memory bus. All of its outputs are registered.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch (I) and load/store (D) requesters.
// Round-robin grant on contention, with a watchdog that errors unacknowledged transactions.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_err,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter holds the number of ISSUE cycles already spent; at this value the current cycle is the last one.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          i_err_q, i_err_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic          busy_q, busy_d;
  logic          gnt_d;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    // D wins unless it was the previous owner and I is also asking.
    gnt_d     = d_req && (!i_req || !last_q);
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d   = gnt_d;
          m_addr_d  = gnt_d ? d_addr : i_addr;
          m_we_d    = gnt_d & d_we;
          m_wdata_d = gnt_d ? d_wdata : '0;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (m_ack) begin
          rdata_d = m_rdata;
          i_ack_d = !owner_q;
          d_ack_d = owner_q;
          m_req_d = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          i_err_d = !owner_q;
          d_err_d = owner_q;
          m_req_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        m_req_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      owner_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      busy_q    <= busy_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = rdata_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule
